// File: rtl/mips_pkg.sv
// Shared widths and the write-back entry type used by the register-file write path.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry;

  // Decode-stage operand bypass: reg 0 reads zero, an in-flight write beats the RF.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] rd,
    input logic [DATA_W-1:0] rf,
    input logic              we,
    input logic [ADDR_W-1:0] wr,
    input logic [DATA_W-1:0] wd
  );
    if (rd == '0)
      return '0;
    else if (we && (wr == rd))
      return wd;
    else
      return rf;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency results until the write port is free.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_entry din,
  output wb_entry dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  wb_entry            mem [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)
        count <= count + CNT_W'(1);
      else if (do_pop && !do_push)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Merges ALU and long-latency results onto the single RF write port, tracks
// pending destinations and bypasses in-flight write data to decode.
module reg_writeback_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_dest,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic              dec_dest_valid,
  input  logic [ADDR_W-1:0] dec_dest,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic              stall,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              regWrite
);

  wb_entry          head;
  wb_entry          in_entry;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  assign mem_ready     = !full;
  assign push          = mem_valid && !full;
  assign pop           = !alu_valid && !empty;
  assign in_entry.dest = mem_dest;
  assign in_entry.data = mem_data;

  wb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Clear is applied before set so a re-issue in the draining cycle keeps the bit.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[head.dest] = 1'b0;
    if (pend_set)
      pending_next[pend_dest] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (alu_valid) begin
      regWrite   <= (alu_dest != '0);
      write_reg  <= alu_dest;
      write_data <= alu_data;
    end else if (!empty) begin
      regWrite   <= (head.dest != '0);
      write_reg  <= head.dest;
      write_data <= head.data;
    end else begin
      regWrite   <= 1'b0;
    end
  end

  assign stall = pending[read_reg_1] | pending[read_reg_2] |
                 (dec_dest_valid & pending[dec_dest]);

  assign fwd_data_1 = fwd_sel(read_reg_1, rf_data_1, regWrite, write_reg, write_data);
  assign fwd_data_2 = fwd_sel(read_reg_2, rf_data_2, regWrite, write_reg, write_data);

endmodule
